// File: rtl/csa_pipe_pkg.sv
// Shared constants and width helpers for the carry-save pipelined accumulator.
package csa_pipe_pkg;

  localparam int N_DEF         = 9;
  localparam int W_DEF         = 4;
  localparam int MAX_BEATS_DEF = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Width that holds the sum of one beat's N operands.
  function automatic int tree_w(input int n, input int w);
    return w + max1(clog2(n));
  endfunction

  function automatic int ow_calc(input int n, input int w, input int max_beats);
    return tree_w(n, w) + max1(clog2(max_beats));
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Parallel-prefix carry-lookahead adder; carry-in is zero and carry-out is dropped.
module carry_lookahead_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  logic [WIDTH-1:0] p0, gk, pk, gn, pn;

  always_comb begin
    p0 = a ^ b;
    gk = a & b;
    pk = p0;
    gn = gk;
    pn = pk;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      gn = gk;
      pn = pk;
      for (int i = d; i < WIDTH; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i-d]);
        pn[i] = pk[i] & pk[i-d];
      end
      gk = gn;
      pk = pn;
    end
    // gk[i] is the carry out of bit i, so the carry into bit i is gk shifted up.
    sum = p0 ^ (gk << 1);
  end
endmodule

// File: rtl/csa_tree_n.sv
// Combinational N-to-2 carry-save reduction of N unsigned W-bit operands.
module csa_tree_n
  import csa_pipe_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  localparam int TW = tree_w(N, W)
) (
  input  logic [N*W-1:0] ops,
  output logic [TW-1:0]  sum,
  output logic [TW-1:0]  carry
);
  wire [N-2:0][TW-1:0] row_s;
  wire [N-2:0][TW-1:0] row_c;

  assign row_s[0] = TW'(ops[0 +: W]);
  assign row_c[0] = TW'(ops[W +: W]);

  for (genvar k = 1; k < N - 1; k++) begin : g_row
    wire [TW-1:0] opk = TW'(ops[(k+1)*W +: W]);
    wire [TW-2:0] cy;
    for (genvar j = 0; j < TW - 1; j++) begin : g_bit
      full_adder u_fa (
        .a   (row_s[k-1][j]),
        .b   (row_c[k-1][j]),
        .cin (opk[j]),
        .s   (row_s[k][j]),
        .cout(cy[j])
      );
    end
    // The total always fits in TW bits, so the top carry can never be set.
    assign row_s[k][TW-1] = row_s[k-1][TW-1] ^ row_c[k-1][TW-1] ^ opk[TW-1];
    assign row_c[k]       = {cy, 1'b0};
  end

  assign sum   = row_s[N-2];
  assign carry = row_c[N-2];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the 3:2 cell of the reduction tree.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/csa_pipe_accum.sv
// Three-stage carry-save frame accumulator: CSA tree, 4:2 accumulator, CLA resolve.
// Optional overflow saturation on frames longer than MAX_BEATS: define CSA_PIPE_OVF_EN.
module csa_pipe_accum
  import csa_pipe_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int W         = W_DEF,
  parameter int MAX_BEATS = MAX_BEATS_DEF,
  localparam int OW       = ow_calc(N, W, MAX_BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [N*W-1:0] i_data,
  input  logic          i_last,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [OW-1:0] o_sum,
  output logic          o_ovf
);
  localparam int TW = tree_w(N, W);

  logic          stall, adv;
  logic [TW-1:0] tree_s, tree_c, s1_s, s1_c;
  logic          s1_v, s1_last, s2_fire, s2_last, s2_ovf;
  logic [OW-1:0] acc_s, acc_c, base_s, base_c, s1s_w, s1c_w;
  logic [OW-1:0] x_s, x_c, nxt_s, nxt_c, res;

  assign stall   = o_valid & ~o_ready;
  assign adv     = ~stall;
  assign i_ready = adv;

  csa_tree_n #(.N(N), .W(W)) u_tree (
    .ops  (i_data),
    .sum  (tree_s),
    .carry(tree_c)
  );

  // 4:2 compression of the accumulator pair with the stage-1 pair; a new frame starts from zero.
  always_comb begin
    s1s_w  = OW'(s1_s);
    s1c_w  = OW'(s1_c);
    base_s = s2_last ? '0 : acc_s;
    base_c = s2_last ? '0 : acc_c;
    x_s    = base_s ^ base_c ^ s1s_w;
    x_c    = ((base_s & base_c) | (base_s & s1s_w) | (base_c & s1s_w)) << 1;
    nxt_s  = x_s ^ x_c ^ s1c_w;
    nxt_c  = ((x_s & x_c) | (x_s & s1c_w) | (x_c & s1c_w)) << 1;
  end

  carry_lookahead_adder #(.WIDTH(OW)) u_cla (
    .a  (acc_s),
    .b  (acc_c),
    .sum(res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_s    <= '0;
      s1_c    <= '0;
      s2_fire <= 1'b0;
      s2_last <= 1'b0;
      acc_s   <= '0;
      acc_c   <= '0;
      o_valid <= 1'b0;
      o_sum   <= '0;
    end else if (adv) begin
      s1_v    <= i_valid;
      s1_last <= i_valid & i_last;
      if (i_valid) begin
        s1_s <= tree_s;
        s1_c <= tree_c;
      end
      s2_fire <= s1_v & s1_last;
      if (s1_v) begin
        acc_s   <= nxt_s;
        acc_c   <= nxt_c;
        s2_last <= s1_last;
      end
      o_valid <= s2_fire;
      if (s2_fire) o_sum <= s2_ovf ? '1 : res;
    end
  end

`ifdef CSA_PIPE_OVF_EN
  localparam int CW = clog2(MAX_BEATS + 2);

  logic [CW-1:0] beat_cnt;
  logic          s1_ovf;

  // beat_cnt holds beats already accepted in this frame, so the current beat is beat_cnt+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      s1_ovf   <= 1'b0;
      s2_ovf   <= 1'b0;
      o_ovf    <= 1'b0;
    end else if (adv) begin
      if (i_valid) begin
        s1_ovf <= (beat_cnt >= CW'(MAX_BEATS));
        if (i_last)                             beat_cnt <= '0;
        else if (beat_cnt != CW'(MAX_BEATS + 1)) beat_cnt <= beat_cnt + 1'b1;
      end
      if (s1_v)    s2_ovf <= s1_ovf;
      if (s2_fire) o_ovf  <= s2_ovf;
    end
  end
`else
  assign s2_ovf = 1'b0;
  assign o_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_csa_pipe_accum.sv
// Scoreboard bench for csa_pipe_accum: directed frames plus random frames under backpressure.
module tb_csa_pipe_accum;
  import csa_pipe_pkg::*;

  localparam int N  = 9;
  localparam int W  = 4;
  localparam int MB = 4;
  localparam int OW = ow_calc(N, W, MB);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [N*W-1:0] i_data = '0;
  logic          i_last = 1'b0;
  logic          o_valid;
  logic          o_ready = 1'b1;
  logic [OW-1:0] o_sum;
  logic          o_ovf;

  always #5 clk = ~clk;

  csa_pipe_accum #(.N(N), .W(W), .MAX_BEATS(MB)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .i_data (i_data),
    .i_last (i_last),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_sum  (o_sum),
    .o_ovf  (o_ovf)
  );

  typedef struct {
    logic [OW-1:0] sum;
    logic          ovf;
    bit            lat;
    int            acc_cyc;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  bit     bp_en    = 1'b0;
  int     hold_lo  = 0;
  longint frame_sum = 0;
  int     frame_beats = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint opsum(input logic [N*W-1:0] d);
    longint s;
    s = 0;
    for (int k = 0; k < N; k++) s += longint'(d[k*W +: W]);
    return s;
  endfunction

  // Downstream ready: forced low while hold_lo counts down, random when bp_en.
  initial begin
    forever begin
      @(negedge clk);
      if (hold_lo > 0) begin
        o_ready = 1'b0;
        hold_lo--;
      end else if (bp_en) o_ready = ($urandom_range(0, 3) != 0);
      else                o_ready = 1'b1;
    end
  end

  // Monitor: checks holding under stall, latency on first appearance, and pops on handshake.
  initial begin
    bit            stalled;
    logic [OW-1:0] hs;
    logic          ho;
    exp_t          e;
    stalled = 1'b0;
    hs = '0;
    ho = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) check("hold_stable", {o_valid, o_ovf, o_sum}, {1'b1, ho, hs});
      if (o_valid) begin
        if (!stalled && exp_q.size() > 0 && exp_q[0].lat)
          check("latency", cyc, exp_q[0].acc_cyc + 2);
        if (!o_ready) begin
          check("stall_iready", i_ready, 0);
          stalled = 1'b1;
          hs = o_sum;
          ho = o_ovf;
        end else begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got sum %0d, expected no output", o_sum);
          end else begin
            e = exp_q.pop_front();
            check("sum", o_sum, e.sum);
            check("ovf", o_ovf, e.ovf);
          end
        end
      end else stalled = 1'b0;
    end
  end

  task automatic send_beat(input logic [N*W-1:0] d, input bit last, input bit use_dir,
                           input int dir_sum, input bit dir_ovf);
    bit   acc;
    int   waited;
    exp_t e;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited <= 200) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = d;
      i_last  = last;
      #1;
      acc = i_ready;
      @(posedge clk);
      #1;
      if (!acc) waited++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: i_ready stayed 0, expected 1 within 200 cycles");
      return;
    end
    frame_sum += opsum(d);
    frame_beats++;
    if (last) begin
      if (use_dir) begin
        e.sum = OW'(dir_sum);
        e.ovf = dir_ovf;
      end else begin
        e.sum = OW'(frame_sum);
        e.ovf = 1'b0;
`ifdef CSA_PIPE_OVF_EN
        if (frame_beats > MB) begin
          e.sum = '1;
          e.ovf = 1'b1;
        end
`endif
      end
      e.lat     = !bp_en && (hold_lo == 0);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
      frame_sum   = 0;
      frame_beats = 0;
    end
  endtask

  task automatic send_frame(input int beats, input bit rnd, input logic [W-1:0] val,
                            input bit use_dir, input int dsum, input bit dovf, input int gap_max);
    logic [N*W-1:0] d;
    for (int b = 0; b < beats; b++) begin
      for (int k = 0; k < N; k++) d[k*W +: W] = rnd ? W'($urandom) : val;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_beat(d, b == beats - 1, use_dir, dsum, dovf);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst     = 1'b1;
    i_valid = 1'b1;
    i_last  = 1'b1;
    for (int k = 0; k < N; k++) i_data[k*W +: W] = W'($urandom);
    exp_q.delete();
    repeat (cycles) @(negedge clk);
    rst     = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    exp_q.delete();
    frame_sum   = 0;
    frame_beats = 0;
    #2;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_sum", o_sum, 0);
    check("rst_o_ovf", o_ovf, 0);
    check("rst_i_ready", i_ready, 1);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (6) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [N*W-1:0] d;
    do_reset(2);

    send_frame(1, 1'b0, 4'd15, 1'b1, 135, 1'b0, 0);
    wait_drain();

    send_frame(4, 1'b0, 4'd15, 1'b1, 540, 1'b0, 0);
    send_frame(4, 1'b0, 4'd1, 1'b1, 36, 1'b0, 0);
    wait_drain();

`ifdef CSA_PIPE_OVF_EN
    send_frame(5, 1'b0, 4'd15, 1'b1, 1023, 1'b1, 0);
`else
    send_frame(5, 1'b0, 4'd15, 1'b1, 675, 1'b0, 0);
`endif
    send_frame(1, 1'b0, 4'd5, 1'b1, 45, 1'b0, 0);
    wait_drain();

    hold_lo = 10;
    send_frame(1, 1'b0, 4'd3, 1'b1, 27, 1'b0, 0);
    send_frame(2, 1'b0, 4'd1, 1'b1, 18, 1'b0, 0);
    wait_drain();
    send_frame(1, 1'b0, 4'd7, 1'b1, 63, 1'b0, 0);
    wait_drain();

    for (int k = 0; k < N; k++) d[k*W +: W] = 4'd9;
    send_beat(d, 1'b0, 1'b0, 0, 1'b0);
    send_beat(d, 1'b0, 1'b0, 0, 1'b0);
    do_reset(1);
    send_frame(1, 1'b0, 4'd2, 1'b1, 18, 1'b0, 0);
    wait_drain();

    bp_en = 1'b1;
    for (int f = 0; f < 60; f++)
      send_frame($urandom_range(1, 6), 1'b1, '0, 1'b0, 0, 1'b0, 2);
    wait_drain();
    bp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
